// File: rtl/fblock_salt_pipe.sv
// DES round function F = P(S(SaltSwap(E(R)) ^ K)) over LANES lanes sharing one crypt(3) salt.
// LATENCY (1..3) CE-high edges from acceptance to OUT_VALID; CE low freezes every stage, no backpressure out.
module fblock_salt_pipe #(
    parameter int LANES     = 1,
    parameter int LATENCY   = 2,
    parameter int SALT_BITS = 12
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic                 IN_VALID,
    input  logic [LANES*32-1:0]  R,
    input  logic [LANES*48-1:0]  K,
    input  logic                 SALT_LOAD,
    input  logic [SALT_BITS-1:0] SALT_IN,
    output logic [SALT_BITS-1:0] SALT_Q,
    output logic                 OUT_VALID,
    output logic [LANES*32-1:0]  F_RK
);
    // One 64-nibble row-major table per S-box; entry 0 sits in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };
    localparam int P_TAB [32] = '{16, 7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
                                   2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
        $error("fblock_salt_pipe: LATENCY must be 1, 2 or 3");
    end
    if (SALT_BITS < 1 || SALT_BITS > 12) begin : g_bad_salt
        $error("fblock_salt_pipe: SALT_BITS must be 1..12");
    end

    logic [SALT_BITS-1:0] salt_q;
    always_ff @(posedge CLK) begin
        if (RST)            salt_q <= '0;
        else if (SALT_LOAD) salt_q <= SALT_IN;
    end
    assign SALT_Q = salt_q;

    logic                 s0_vld;
    logic [LANES*32-1:0]  s0_r;
    logic [LANES*48-1:0]  s0_k;
    logic [SALT_BITS-1:0] s0_salt;

    // The salt is latched with the item so later loads cannot reach it.
    if (LATENCY >= 3) begin : g_in_reg
        logic                 in_vld_q;
        logic [LANES*32-1:0]  in_r_q;
        logic [LANES*48-1:0]  in_k_q;
        logic [SALT_BITS-1:0] in_salt_q;
        always_ff @(posedge CLK) begin
            if (RST) begin
                in_vld_q  <= 1'b0;
                in_r_q    <= '0;
                in_k_q    <= '0;
                in_salt_q <= '0;
            end else if (CE) begin
                in_vld_q <= IN_VALID;
                if (IN_VALID) begin
                    in_r_q    <= R;
                    in_k_q    <= K;
                    in_salt_q <= salt_q;
                end
            end
        end
        assign s0_vld  = in_vld_q;
        assign s0_r    = in_r_q;
        assign s0_k    = in_k_q;
        assign s0_salt = in_salt_q;
    end else begin : g_in_pass
        assign s0_vld  = IN_VALID;
        assign s0_r    = R;
        assign s0_k    = K;
        assign s0_salt = salt_q;
    end

    logic [LANES*48-1:0] x_d;
    logic [LANES*48-1:0] x_s;
    logic                x_vld;

    if (LATENCY >= 2) begin : g_x_reg
        logic                x_vld_q;
        logic [LANES*48-1:0] x_q;
        always_ff @(posedge CLK) begin
            if (RST) begin
                x_vld_q <= 1'b0;
                x_q     <= '0;
            end else if (CE) begin
                x_vld_q <= s0_vld;
                if (s0_vld) x_q <= x_d;
            end
        end
        assign x_vld = x_vld_q;
        assign x_s   = x_q;
    end else begin : g_x_pass
        assign x_vld = s0_vld;
        assign x_s   = x_d;
    end

    logic [LANES*32-1:0] f_d;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic [31:0] r_l;
        logic [47:0] e_l;
        logic [47:0] sw_l;
        logic [47:0] x_l;
        logic [31:0] s_l;
        logic [31:0] f_l;

        assign r_l = s0_r[32*n +: 32];
        // E groups g take DES bits 4g..4g+5, wrapping 0->32 and 33->1.
        for (genvar i = 1; i <= 48; i++) begin : g_e
            localparam int RAW = 4 * ((i - 1) / 6) + (i - 1) % 6;
            localparam int SRC = (RAW == 0) ? 32 : ((RAW == 33) ? 1 : RAW);
            assign e_l[48-i] = r_l[32-SRC];
        end
        for (genvar j = 0; j < 24; j++) begin : g_sw
            if (j < SALT_BITS) begin : g_on
                assign sw_l[47-j] = s0_salt[j] ? e_l[23-j] : e_l[47-j];
                assign sw_l[23-j] = s0_salt[j] ? e_l[47-j] : e_l[23-j];
            end else begin : g_off
                assign sw_l[47-j] = e_l[47-j];
                assign sw_l[23-j] = e_l[23-j];
            end
        end
        assign x_d[48*n +: 48] = sw_l ^ s0_k[48*n +: 48];

        assign x_l = x_s[48*n +: 48];
        for (genvar m = 0; m < 8; m++) begin : g_sb
            localparam logic [255:0] SB = SBOX[m];
            logic [5:0] c;
            logic [5:0] idx;
            assign c   = x_l[47-6*m -: 6];
            assign idx = {c[5], c[0], c[4:1]};
            assign s_l[31-4*m -: 4] = SB[{~idx, 2'b00} +: 4];
        end
        for (genvar i = 1; i <= 32; i++) begin : g_p
            assign f_l[32-i] = s_l[32-P_TAB[i-1]];
        end
        assign f_d[32*n +: 32] = f_l;
    end

    logic                out_vld_q;
    logic [LANES*32-1:0] f_q;
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_vld_q <= 1'b0;
            f_q       <= '0;
        end else if (CE) begin
            out_vld_q <= x_vld;
            if (x_vld) f_q <= f_d;
        end
    end
    assign OUT_VALID = out_vld_q;
    assign F_RK      = f_q;

endmodule
